hall_conditioner: RTL and testbench
===================================

# hall_conditioner

Front-end stage for the BLDC controller: synchronizes and debounces the three raw hall-sensor inputs. It decodes the filtered code into a commutation sector and feeds that sector to the commutation/gate-drive stage. It also derives rotation direction and the electrical-sector period in clocks, and flags illegal hall codes or sequences.

## Interface
- FILT_CYC, default 4: consecutive stable cycles required before a new hall code is accepted (≥1).
- PER_W, default 16: width of the period counter and of PERIOD.
- CLK  in  1  system clock, rising-edge.
- RST  in  1  reset, synchronous, active-high.
- H1, H2, H3  in  1 each  raw, asynchronous hall inputs.
- HALL  out  3  filtered code {H3,H2,H1}.
- SECTOR  out  3  decoded sector 0–5; 7 = invalid.
- VALID  out  1  HALL holds a legal code.
- EDGE  out  1  one-cycle pulse when HALL changes to a legal code.
- DIR  out  1  1 = forward, 0 = reverse.
- PERIOD  out  PER_W  clocks between the last two EDGE pulses.
- PER_VLD  out  1  one-cycle pulse when PERIOD is updated.
- STALL  out  1  period counter saturated since the last EDGE.
- FAULT  out  1  sticky error flag.

## Operation
- Sector map for {H3,H2,H1}:
  - 001→0, 101→1, 100→2, 110→3, 010→4, 011→5.
  - 000 and 111 are illegal.
  - Forward rotation is ascending sector, mod 6.
- Input conditioning:
  - Each raw input passes through two synchronizer flops.
  - The synchronized 3-bit code is loaded into a candidate register with a stable counter. The counter clears whenever the candidate changes.
  - HALL loads the candidate when the candidate ≠ HALL and the candidate has been stable for FILT_CYC cycles.
- Legal new code:
  - SECTOR is updated, VALID=1, and EDGE pulses.
  - DIR evaluation applies only when the previous HALL was also legal and one EDGE has occurred since reset:
    - new sector = old+1 mod 6 → DIR=1.
    - new sector = old−1 mod 6 → DIR=0.
    - any other jump → DIR unchanged, FAULT=1.
- Illegal new code: SECTOR=7, VALID=0, FAULT=1, no EDGE pulse.
- FAULT clears only on RST.
- Period counter:
  - Increments every cycle and saturates at 2^PER_W−1.
  - On EDGE, PERIOD ← counter+1 and the counter clears to 0.
  - PER_VLD pulses on an EDGE only if both of these hold:
    - it is not the first EDGE since reset;
    - the counter was not saturated.
  - STALL=1 while the counter is saturated, and clears on the next EDGE.
  - The period is measured between the two EDGE pulses that bracket it; an intervening illegal code does not clear the counter.
- Reset values:
  - HALL=000, SECTOR=7, VALID=0, EDGE=0, DIR=1.
  - PERIOD=0, PER_VLD=0, STALL=0, FAULT=0.
  - Synchronizer, candidate and counters are all cleared.
  - The first legal code after reset produces EDGE but no DIR or FAULT evaluation.

## Timing
- Raw input change first sampled on edge 1 → HALL, SECTOR, VALID and EDGE update on edge 3+FILT_CYC (edge 7 at the default).
- A glitch that is not held stable for FILT_CYC synchronized cycles never reaches HALL.
- PERIOD and PER_VLD update on the same edge as EDGE.
- If edges occur at cycles t and t+N, then PERIOD=N.
- If EDGE and saturation occur on the same cycle, EDGE wins and the counter clears.
- RST mid-operation overrides everything on that edge, and all outputs take their reset values on the next edge.
- No combinational input-to-output paths; all outputs are registered.

## Structure
- Shared package hall_pkg contains:
  - the SECTOR_INVALID=3'd7 constant;
  - a code-to-sector function;
  - next/prev-sector functions (mod 6).
- The commutation stage imports the same package.
- One natural sub-module, hall_filter: 2-flop sync plus the FILT_CYC stability filter on a 3-bit bus.
- The decode, direction and period logic stays in hall_conditioner.

## Test plan
- **Forward sweep:** 20 ns CLK; codes 001→101→100→110→010→011→001, each held 50 cycles → EDGE every 50 cycles, SECTOR 0→5→0, DIR=1, PERIOD=50 with PER_VLD from the second EDGE onward, FAULT=0.
- **Reverse sweep:** the same sequence reversed → DIR=0 after the second EDGE, PERIOD=50, FAULT=0.
- **Glitch rejection:** while 001 is held, a 3-cycle pulse on H2 (FILT_CYC=4) → HALL stays 001, no EDGE; a 4-cycle hold of 011 → HALL=011, EDGE once.
- **Illegal code and skip:** 001→111 → SECTOR=7, VALID=0, FAULT=1; after RST, 001→100 → EDGE, FAULT=1, DIR unchanged.
- **Stall:** PER_W=8, hold a code for 300 cycles → STALL=1 after 255 cycles; next EDGE → no PER_VLD, STALL=0.
- **Reset mid-stream:** assert RST one cycle during a sweep → all outputs at reset values next edge; first subsequent EDGE has no PER_VLD.

Source files
------------

// File: rtl/hall_pkg.sv
// Shared hall-sensor definitions: sector encoding, direction values and
// mod-6 sector arithmetic used by the conditioner and the commutation stage.
package hall_pkg;

  localparam logic [2:0] SECTOR_INVALID = 3'd7;
  localparam logic [2:0] SECTOR_LAST    = 3'd5;

  typedef enum logic {
    DIR_REV = 1'b0,
    DIR_FWD = 1'b1
  } dir_e;

  function automatic logic [2:0] code_to_sector(input logic [2:0] code);
    case (code)
      3'b001:  return 3'd0;
      3'b101:  return 3'd1;
      3'b100:  return 3'd2;
      3'b110:  return 3'd3;
      3'b010:  return 3'd4;
      3'b011:  return 3'd5;
      default: return SECTOR_INVALID;
    endcase
  endfunction

  function automatic logic [2:0] next_sector(input logic [2:0] s);
    return (s == SECTOR_LAST) ? 3'd0 : s + 3'd1;
  endfunction

  function automatic logic [2:0] prev_sector(input logic [2:0] s);
    return (s == 3'd0) ? SECTOR_LAST : s - 3'd1;
  endfunction

endpackage

// File: rtl/hall_filter.sv
// Two-flop synchronizer plus stability filter on the 3-bit hall bus.
// stable asserts once the candidate has been held for FILT_CYC cycles.
module hall_filter #(
  parameter int FILT_CYC = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] raw,
  output logic [2:0] cand,
  output logic       stable
);

  localparam int CW = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYC - 1);

  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [CW-1:0] cnt;

  // NOTE: every flop uses <= so each stage samples the pre-edge value of the one before it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= '0;
      sync2 <= '0;
      cand  <= '0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= '0;
      end else if (cnt != CNT_LAST) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // cnt == FILT_CYC-1 means the candidate has been held for FILT_CYC cycles.
  assign stable = (cnt == CNT_LAST);

endmodule

// File: rtl/hall_conditioner.sv
// Hall front end: filtered code, sector decode, rotation direction,
// electrical-sector period measurement and sticky fault detection.
module hall_conditioner
  import hall_pkg::*;
#(
  parameter int FILT_CYC = 4,
  parameter int PER_W    = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             H1,
  input  logic             H2,
  input  logic             H3,
  output logic [2:0]       HALL,
  output logic [2:0]       SECTOR,
  output logic             VALID,
  output logic             EDGE,
  output logic             DIR,
  output logic [PER_W-1:0] PERIOD,
  output logic             PER_VLD,
  output logic             STALL,
  output logic             FAULT
);

  localparam logic [PER_W-1:0] CNT_MAX = '1;

  logic [2:0]       cand;
  logic             stable;
  logic             accept;
  logic [2:0]       new_sector;
  logic             new_legal;
  logic             edge_now;
  logic             seen_edge;
  logic [PER_W-1:0] cnt;
  logic [PER_W-1:0] cnt_next;

  hall_filter #(.FILT_CYC(FILT_CYC)) u_filter (
    .CLK   (CLK),
    .RST   (RST),
    .raw   ({H3, H2, H1}),
    .cand  (cand),
    .stable(stable)
  );

  assign accept     = stable && (cand != HALL);
  assign new_sector = code_to_sector(cand);
  assign new_legal  = (new_sector != SECTOR_INVALID);
  assign edge_now   = accept && new_legal;
  // The counter keeps running across illegal codes; only a legal edge clears it.
  assign cnt_next   = edge_now ? '0 : (cnt == CNT_MAX) ? cnt : cnt + PER_W'(1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      HALL      <= 3'b000;
      SECTOR    <= SECTOR_INVALID;
      VALID     <= 1'b0;
      EDGE      <= 1'b0;
      DIR       <= DIR_FWD;
      PERIOD    <= '0;
      PER_VLD   <= 1'b0;
      STALL     <= 1'b0;
      FAULT     <= 1'b0;
      seen_edge <= 1'b0;
      cnt       <= '0;
    end else begin
      EDGE    <= edge_now;
      PER_VLD <= edge_now && seen_edge && (cnt != CNT_MAX);
      cnt     <= cnt_next;
      STALL   <= (cnt_next == CNT_MAX);
      if (accept) begin
        HALL   <= cand;
        SECTOR <= new_sector;
        VALID  <= new_legal;
        if (!new_legal) begin
          FAULT <= 1'b1;
        end else begin
          seen_edge <= 1'b1;
          PERIOD    <= cnt + PER_W'(1);
          // Direction is only judged between two consecutive legal codes.
          if (seen_edge && VALID) begin
            if (new_sector == next_sector(SECTOR))      DIR   <= DIR_FWD;
            else if (new_sector == prev_sector(SECTOR)) DIR   <= DIR_REV;
            else                                        FAULT <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_hall_conditioner.sv
// Self-checking bench for hall_conditioner: directed scenarios plus random
// hall sequences compared every cycle against a behavioural model.
module tb_hall_conditioner;

  localparam int FILT_CYC = 4;
  localparam int PER_W    = 8;
  localparam int SAT      = (1 << PER_W) - 1;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             H1 = 1'b0, H2 = 1'b0, H3 = 1'b0;
  logic [2:0]       HALL, SECTOR;
  logic             VALID, EDGE, DIR, PER_VLD, STALL, FAULT;
  logic [PER_W-1:0] PERIOD;

  hall_conditioner #(.FILT_CYC(FILT_CYC), .PER_W(PER_W)) dut (
    .CLK(CLK), .RST(RST), .H1(H1), .H2(H2), .H3(H3),
    .HALL(HALL), .SECTOR(SECTOR), .VALID(VALID), .EDGE(EDGE), .DIR(DIR),
    .PERIOD(PERIOD), .PER_VLD(PER_VLD), .STALL(STALL), .FAULT(FAULT)
  );

  always #10 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;
  int edge_cnt = 0;
  int pv_cnt   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Forward order of hall codes, index = sector.
  logic [2:0] fwd_codes [6] = '{3'b001, 3'b101, 3'b100, 3'b110, 3'b010, 3'b011};

  function automatic int sector_of(input logic [2:0] c);
    for (int i = 0; i < 6; i++) if (fwd_codes[i] == c) return i;
    return 7;
  endfunction

  // ---------------- behavioural model ----------------
  // HALL at edge n takes the raw sample from edge n-3 once that value had been
  // sampled on at least FILT_CYC consecutive edges and differs from HALL.
  int         cyc = 0, anchor = 0;
  bit         seen = 1'b0;
  logic [2:0] hv [3];
  int         hr [3];
  logic [2:0] e_hall = 3'b000;
  int         e_sector = 7, e_period = 0;
  bit         e_valid = 0, e_edge = 0, e_dir = 1, e_pervld = 0, e_stall = 0, e_fault = 0;
  logic [2:0] m_smp, m_old;
  int         m_oldr, m_newr, m_el, m_s, m_d;

  always @(posedge CLK) begin
    cyc++;
    m_smp = {H3, H2, H1};
    if (RST) begin
      hv = '{3'b000, 3'b000, 3'b000};
      hr = '{3, 2, 1};
      anchor = cyc; seen = 0;
      e_hall = 3'b000; e_sector = 7; e_valid = 0; e_edge = 0; e_dir = 1;
      e_period = 0; e_pervld = 0; e_stall = 0; e_fault = 0;
    end else begin
      m_old = hv[2]; m_oldr = hr[2];
      e_edge = 0; e_pervld = 0;
      if (m_oldr >= FILT_CYC && m_old != e_hall) begin
        e_hall = m_old;
        m_s = sector_of(m_old);
        if (m_s == 7) begin
          e_sector = 7; e_valid = 0; e_fault = 1;
        end else begin
          m_el = cyc - anchor;
          e_period = (m_el <= SAT) ? m_el : 0;
          e_pervld = seen && (m_el <= SAT);
          if (seen && e_valid) begin
            m_d = (m_s - e_sector + 6) % 6;
            if (m_d == 1)      e_dir = 1;
            else if (m_d == 5) e_dir = 0;
            else               e_fault = 1;
          end
          e_sector = m_s; e_valid = 1; e_edge = 1; seen = 1; anchor = cyc;
        end
      end
      e_stall = (cyc - anchor) >= SAT;
      m_newr = (m_smp == hv[0]) ? ((hr[0] < 100000) ? hr[0] + 1 : hr[0]) : 1;
      hv[2] = hv[1]; hr[2] = hr[1];
      hv[1] = hv[0]; hr[1] = hr[0];
      hv[0] = m_smp; hr[0] = m_newr;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK) begin
    if (chk_en) begin
      check("hall",    32'(HALL),    32'(e_hall));
      check("sector",  32'(SECTOR),  32'(e_sector));
      check("valid",   32'(VALID),   32'(e_valid));
      check("edge",    32'(EDGE),    32'(e_edge));
      check("dir",     32'(DIR),     32'(e_dir));
      check("period",  32'(PERIOD),  32'(e_period));
      check("per_vld", 32'(PER_VLD), 32'(e_pervld));
      check("stall",   32'(STALL),   32'(e_stall));
      check("fault",   32'(FAULT),   32'(e_fault));
      if (EDGE)    edge_cnt++;
      if (PER_VLD) pv_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic set_code(input logic [2:0] c);
    {H3, H2, H1} = c;
  endtask

  task automatic wait_edge(input int limit, output int k);
    k = 0;
    for (int i = 1; i <= limit; i++) begin
      step(1);
      if (EDGE) begin
        k = i;
        return;
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_hall"},    32'(HALL),    32'd0);
    check({tag, "_sector"},  32'(SECTOR),  32'd7);
    check({tag, "_valid"},   32'(VALID),   32'd0);
    check({tag, "_edge"},    32'(EDGE),    32'd0);
    check({tag, "_dir"},     32'(DIR),     32'd1);
    check({tag, "_period"},  32'(PERIOD),  32'd0);
    check({tag, "_per_vld"}, 32'(PER_VLD), 32'd0);
    check({tag, "_stall"},   32'(STALL),   32'd0);
    check({tag, "_fault"},   32'(FAULT),   32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int k, e0, p0, cur;
  int rsel;
  logic [2:0] rc;

  initial begin
    set_code(3'b000);
    RST = 1'b1;
    step(3);
    chk_en = 1'b1;
    check_reset_vals("reset");

    // Latency: raw change before edge 1 appears on edge 3+FILT_CYC.
    RST = 1'b0;
    set_code(3'b001);
    wait_edge(20, k);
    check("first_edge_latency", 32'(k), 32'd7);
    check("first_edge_no_pervld", 32'(PER_VLD), 32'd0);
    step(43);

    // Forward sweep, 50 cycles per code.
    e0 = edge_cnt; p0 = pv_cnt;
    for (int i = 1; i <= 6; i++) begin
      set_code(fwd_codes[i % 6]);
      step(50);
    end
    check("fwd_edges",  32'(edge_cnt - e0), 32'd6);
    check("fwd_pervld", 32'(pv_cnt - p0),   32'd6);
    check("fwd_period", 32'(PERIOD), 32'd50);
    check("fwd_model_period", 32'(e_period), 32'd50);
    check("fwd_dir",    32'(DIR),    32'd1);
    check("fwd_sector", 32'(SECTOR), 32'd0);
    check("fwd_fault",  32'(FAULT),  32'd0);

    // Reverse sweep.
    e0 = edge_cnt;
    for (int i = 5; i >= 0; i--) begin
      set_code(fwd_codes[i]);
      step(50);
    end
    check("rev_edges",  32'(edge_cnt - e0), 32'd6);
    check("rev_period", 32'(PERIOD), 32'd50);
    check("rev_dir",    32'(DIR),    32'd0);
    check("rev_fault",  32'(FAULT),  32'd0);

    // Glitch rejection: 3-cycle pulse on H2 is dropped, 4-cycle one passes.
    e0 = edge_cnt;
    set_code(3'b011); step(3);
    set_code(3'b001); step(20);
    check("glitch3_hall",  32'(HALL), 32'd1);
    check("glitch3_edges", 32'(edge_cnt - e0), 32'd0);
    set_code(3'b011); step(4);
    set_code(3'b001); step(3);
    check("glitch4_hall",  32'(HALL), 32'd3);
    check("glitch4_edges", 32'(edge_cnt - e0), 32'd1);
    step(20);
    check("glitch4_back",  32'(HALL), 32'd1);

    // Illegal code.
    set_code(3'b111); step(10);
    check("illegal_sector", 32'(SECTOR), 32'd7);
    check("illegal_valid",  32'(VALID),  32'd0);
    check("illegal_fault",  32'(FAULT),  32'd1);

    // Skip after reset: 001 -> 100 is two sectors forward.
    RST = 1'b1; set_code(3'b001); step(1);
    RST = 1'b0; step(20);
    check("skip_first_sector", 32'(SECTOR), 32'd0);
    check("skip_first_fault",  32'(FAULT),  32'd0);
    set_code(3'b100); step(20);
    check("skip_sector", 32'(SECTOR), 32'd2);
    check("skip_fault",  32'(FAULT),  32'd1);
    check("skip_dir",    32'(DIR),    32'd1);

    // Stall: counter saturates 255 cycles after the last edge.
    RST = 1'b1; set_code(3'b001); step(1);
    RST = 1'b0;
    wait_edge(20, k);
    check("stall_first_edge", 32'(k != 0), 32'd1);
    k = 0;
    for (int i = 1; i <= 400; i++) begin
      step(1);
      if (STALL) begin
        k = i;
        break;
      end
    end
    check("stall_cycles", 32'(k), 32'd255);
    step(20);
    set_code(3'b101);
    wait_edge(20, k);
    check("stall_edge_seen", 32'(k != 0), 32'd1);
    check("stall_no_pervld", 32'(PER_VLD), 32'd0);
    check("stall_cleared",   32'(STALL),   32'd0);

    // Reset mid-stream.
    set_code(3'b100); step(50);
    set_code(3'b110); step(20);
    RST = 1'b1; step(1);
    check_reset_vals("midrst");
    RST = 1'b0;
    wait_edge(20, k);
    check("midrst_edge_seen", 32'(k != 0), 32'd1);
    check("midrst_no_pervld", 32'(PER_VLD), 32'd0);
    step(10);

    // Random sequences: neighbours, skips, glitches, illegal codes and resets.
    cur = 3;
    for (int it = 0; it < 220; it++) begin
      rsel = int'($urandom_range(0, 99));
      if (rsel < 4) begin
        RST = 1'b1;
        step(int'($urandom_range(1, 2)));
        RST = 1'b0;
      end else begin
        if (rsel < 14)      rc = 3'($urandom_range(0, 7));
        else if (rsel < 20) rc = fwd_codes[(cur + int'($urandom_range(2, 4))) % 6];
        else                rc = fwd_codes[(cur + (($urandom_range(0, 1) == 0) ? 1 : 5)) % 6];
        if (sector_of(rc) != 7) cur = sector_of(rc);
        set_code(rc);
        step(int'($urandom_range(1, 12)));
      end
    end
    step(12);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
